// File: rtl/router_pkg.sv
// Shared constants, header field helpers and FSM state encoding for the 1x3 router.
package router_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned LEN_W   = DATA_W - ADDR_W;
    localparam int unsigned LEN_LSB = ADDR_W;
    localparam int unsigned LEN_MSB = DATA_W - 1;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } router_state_e;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
        return hdr[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity over header and payload bytes; clear beats load beats xor.
module router_parity_acc
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              xor_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] int_par
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            int_par <= '0;
        end else if (clear) begin
            int_par <= '0;
        end else if (load) begin
            int_par <= din;
        end else if (xor_en) begin
            int_par <= int_par ^ din;
        end
    end

endmodule

// File: rtl/router_reg_stage.sv
// Router byte datapath: header latch, FIFO-full hold, parity capture/check.
// Optional payload length check enabled by defining ROUTER_REG_LEN_CHECK_EN.
module router_reg_stage
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              pkt_vld,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd,
    input  logic              ld,
    input  logic              laf,
    input  logic              full,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_pkt_vld,
`ifdef ROUTER_REG_LEN_CHECK_EN
    output logic              len_err,
`endif
    output logic              err
);

    logic [DATA_W-1:0] hdr_q;
    logic [DATA_W-1:0] full_q;
    logic [DATA_W-1:0] pkt_par;
    logic [DATA_W-1:0] int_par;
    logic              payload_wr_c;
    logic [DATA_W-1:0] par_din_c;

    // A byte replayed by laf before pkt_vld fell is payload; afterwards it is the parity byte.
    assign payload_wr_c = (ld && pkt_vld && !fifo_full) || (laf && !low_pkt_vld);
    assign par_din_c    = ld ? din : full_q;

    router_parity_acc u_parity_acc (
        .clk     (clk),
        .rst     (rst),
        .clear   (detect_add),
        .load    (lfd),
        .xor_en  (payload_wr_c),
        .din     (lfd ? hdr_q : par_din_c),
        .int_par (int_par)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout        <= '0;
            hdr_q       <= '0;
            full_q      <= '0;
            pkt_par     <= '0;
            parity_done <= 1'b0;
            low_pkt_vld <= 1'b0;
            err         <= 1'b0;
        end else if (detect_add) begin
            if (pkt_vld) begin
                hdr_q <= din;
            end
            pkt_par     <= '0;
            parity_done <= 1'b0;
            err         <= 1'b0;
        end else if (lfd) begin
            dout <= hdr_q;
        end else if (ld) begin
            if (fifo_full) begin
                full_q <= din;
            end else begin
                dout <= din;
            end
            if (!pkt_vld) begin
                low_pkt_vld <= 1'b1;
                if (!fifo_full) begin
                    pkt_par     <= din;
                    parity_done <= 1'b1;
                end
            end
        end else if (laf) begin
            dout <= full_q;
            if (low_pkt_vld && !parity_done) begin
                pkt_par     <= full_q;
                parity_done <= 1'b1;
            end
        end else if (rst_int_reg) begin
            low_pkt_vld <= 1'b0;
            if (parity_done) begin
                err <= (int_par != pkt_par);
            end
        end
    end

`ifdef ROUTER_REG_LEN_CHECK_EN
    logic [LEN_W-1:0] pay_cnt;

    // Payload byte counter compared against the header length field at check time.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pay_cnt <= '0;
            len_err <= 1'b0;
        end else begin
            if (lfd) begin
                pay_cnt <= '0;
            end else if (payload_wr_c) begin
                pay_cnt <= pay_cnt + LEN_W'(1);
            end
            if (detect_add) begin
                len_err <= 1'b0;
            end else if (rst_int_reg) begin
                len_err <= (pay_cnt != hdr_len(hdr_q));
            end
        end
    end
`endif

    // Control flags come from a one-hot FSM state decode.
    a_flags_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0({detect_add, lfd, ld, laf, full, rst_int_reg}));

endmodule

// File: tb/tb_router_reg_stage.sv
// Directed self-checking bench for router_reg_stage (define ROUTER_REG_LEN_CHECK_EN for len_err checks).
module tb_router_reg_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       pkt_vld;
    logic       fifo_full;
    logic       detect_add, lfd, ld, laf, full, rst_int_reg;
    logic [7:0] dout;
    logic       parity_done, low_pkt_vld, err;
`ifdef ROUTER_REG_LEN_CHECK_EN
    logic       len_err;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] F_NONE = 6'b000000;
    localparam logic [5:0] F_DA   = 6'b100000;
    localparam logic [5:0] F_LFD  = 6'b010000;
    localparam logic [5:0] F_LD   = 6'b001000;
    localparam logic [5:0] F_LAF  = 6'b000100;
    localparam logic [5:0] F_FULL = 6'b000010;
    localparam logic [5:0] F_RIR  = 6'b000001;

    always #5 clk = ~clk;

    router_reg_stage dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .pkt_vld     (pkt_vld),
        .fifo_full   (fifo_full),
        .detect_add  (detect_add),
        .lfd         (lfd),
        .ld          (ld),
        .laf         (laf),
        .full        (full),
        .rst_int_reg (rst_int_reg),
        .dout        (dout),
        .parity_done (parity_done),
        .low_pkt_vld (low_pkt_vld),
`ifdef ROUTER_REG_LEN_CHECK_EN
        .len_err     (len_err),
`endif
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic step(input logic [5:0] f, input logic [7:0] d, input logic v, input logic ff);
        {detect_add, lfd, ld, laf, full, rst_int_reg} = f;
        din       = d;
        pkt_vld   = v;
        fifo_full = ff;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        step(F_NONE, 8'h00, 1'b0, 1'b0);
        step(F_NONE, 8'h00, 1'b0, 1'b0);
        check("rst dout", dout, 8'h00);
        check("rst parity_done", parity_done, 1'b0);
        check("rst low_pkt_vld", low_pkt_vld, 1'b0);
        check("rst err", err, 1'b0);
        rst = 1'b1;

        // 1: clean packet 0D A1 B2 C3 DD
        step(F_DA,  8'h0D, 1'b1, 1'b0); check("t1 dout hold at da", dout, 8'h00);
        step(F_LFD, 8'hA1, 1'b1, 1'b0); check("t1 dout hdr", dout, 8'h0D);
        step(F_LD,  8'hA1, 1'b1, 1'b0); check("t1 dout a1", dout, 8'hA1);
        step(F_LD,  8'hB2, 1'b1, 1'b0); check("t1 dout b2", dout, 8'hB2);
        step(F_LD,  8'hC3, 1'b1, 1'b0); check("t1 dout c3", dout, 8'hC3);
        check("t1 pd before parity", parity_done, 1'b0);
        step(F_LD,  8'hDD, 1'b0, 1'b0); check("t1 dout par", dout, 8'hDD);
        check("t1 parity_done", parity_done, 1'b1);
        check("t1 low_pkt_vld", low_pkt_vld, 1'b1);
        step(F_RIR, 8'h00, 1'b0, 1'b0); check("t1 err", err, 1'b0);
        check("t1 low cleared", low_pkt_vld, 1'b0);
`ifdef ROUTER_REG_LEN_CHECK_EN
        check("t1 len_err", len_err, 1'b0);
`endif
        step(F_NONE, 8'h00, 1'b0, 1'b0);

        // 2: bad parity DC
        step(F_DA,  8'h0D, 1'b1, 1'b0); check("t2 pd cleared", parity_done, 1'b0);
        step(F_LFD, 8'hA1, 1'b1, 1'b0);
        step(F_LD,  8'hA1, 1'b1, 1'b0);
        step(F_LD,  8'hB2, 1'b1, 1'b0);
        step(F_LD,  8'hC3, 1'b1, 1'b0);
        step(F_LD,  8'hDC, 1'b0, 1'b0); check("t2 dout par", dout, 8'hDC);
        check("t2 err before check", err, 1'b0);
        step(F_RIR, 8'h00, 1'b0, 1'b0); check("t2 err set", err, 1'b1);
        step(F_NONE, 8'h00, 1'b0, 1'b0); check("t2 err sticky", err, 1'b1);

        // 3: FIFO full while B2 arrives
        step(F_DA,  8'h0D, 1'b1, 1'b0); check("t3 err cleared by da", err, 1'b0);
        step(F_LFD, 8'hA1, 1'b1, 1'b0);
        step(F_LD,  8'hA1, 1'b1, 1'b0); check("t3 dout a1", dout, 8'hA1);
        step(F_LD,  8'hB2, 1'b1, 1'b1); check("t3 hold a1 #1", dout, 8'hA1);
        step(F_FULL, 8'hB2, 1'b1, 1'b1); check("t3 hold a1 #2", dout, 8'hA1);
        step(F_FULL, 8'hB2, 1'b1, 1'b1); check("t3 hold a1 #3", dout, 8'hA1);
        step(F_LAF, 8'hB2, 1'b1, 1'b0); check("t3 laf b2", dout, 8'hB2);
        check("t3 pd after laf", parity_done, 1'b0);
        step(F_LD,  8'hC3, 1'b1, 1'b0); check("t3 dout c3", dout, 8'hC3);
        step(F_LD,  8'hDD, 1'b0, 1'b0); check("t3 dout par", dout, 8'hDD);
        step(F_RIR, 8'h00, 1'b0, 1'b0); check("t3 err", err, 1'b0);
`ifdef ROUTER_REG_LEN_CHECK_EN
        check("t3 len_err", len_err, 1'b0);
`endif
        step(F_NONE, 8'h00, 1'b0, 1'b0);

        // 4: FIFO full on the parity byte
        step(F_DA,  8'h0D, 1'b1, 1'b0);
        step(F_LFD, 8'hA1, 1'b1, 1'b0);
        step(F_LD,  8'hA1, 1'b1, 1'b0);
        step(F_LD,  8'hB2, 1'b1, 1'b0);
        step(F_LD,  8'hC3, 1'b1, 1'b0);
        step(F_LD,  8'hDD, 1'b0, 1'b1); check("t4 dout holds c3", dout, 8'hC3);
        check("t4 pd not yet", parity_done, 1'b0);
        check("t4 low set", low_pkt_vld, 1'b1);
        step(F_FULL, 8'hDD, 1'b0, 1'b1); check("t4 hold c3", dout, 8'hC3);
        step(F_LAF, 8'hDD, 1'b0, 1'b0); check("t4 laf par", dout, 8'hDD);
        check("t4 parity_done", parity_done, 1'b1);
        step(F_RIR, 8'h00, 1'b0, 1'b0); check("t4 err", err, 1'b0);
`ifdef ROUTER_REG_LEN_CHECK_EN
        check("t4 len_err", len_err, 1'b0);
`endif
        step(F_NONE, 8'h00, 1'b0, 1'b0);

        // 5: reset mid-payload, then short packet 05 7F 7A
        step(F_DA,  8'h0D, 1'b1, 1'b0);
        step(F_LFD, 8'hA1, 1'b1, 1'b0);
        step(F_LD,  8'hA1, 1'b1, 1'b0);
        step(F_LD,  8'hB2, 1'b0, 1'b0);
        rst = 1'b0;
        step(F_NONE, 8'h00, 1'b0, 1'b0); check("t5 rst dout", dout, 8'h00);
        check("t5 rst pd", parity_done, 1'b0);
        check("t5 rst low", low_pkt_vld, 1'b0);
        rst = 1'b1;
        step(F_DA,  8'h05, 1'b1, 1'b0);
        step(F_LFD, 8'h7F, 1'b1, 1'b0); check("t5 dout hdr", dout, 8'h05);
        step(F_LD,  8'h7F, 1'b1, 1'b0); check("t5 dout 7f", dout, 8'h7F);
        step(F_LD,  8'h7A, 1'b0, 1'b0); check("t5 dout par", dout, 8'h7A);
        check("t5 parity_done", parity_done, 1'b1);
        step(F_RIR, 8'h00, 1'b0, 1'b0); check("t5 err", err, 1'b0);
`ifdef ROUTER_REG_LEN_CHECK_EN
        check("t5 len_err", len_err, 1'b0);
        step(F_NONE, 8'h00, 1'b0, 1'b0);

        // 6: header says 3 bytes, only 2 sent; parity 0D^A1^B2 = 1E
        step(F_DA,  8'h0D, 1'b1, 1'b0);
        step(F_LFD, 8'hA1, 1'b1, 1'b0);
        step(F_LD,  8'hA1, 1'b1, 1'b0);
        step(F_LD,  8'hB2, 1'b1, 1'b0);
        step(F_LD,  8'h1E, 1'b0, 1'b0);
        step(F_RIR, 8'h00, 1'b0, 1'b0); check("t6 len_err", len_err, 1'b1);
        check("t6 err", err, 1'b0);
        step(F_DA,  8'h05, 1'b1, 1'b0); check("t6 len_err cleared", len_err, 1'b0);
`endif

        step(F_NONE, 8'h00, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
